// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, length, 16-bit words (high byte first) and checksum.
// Writes words into instruction memory and holds the CPU until a checksum-valid program has landed.
module prog_loader #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int          TIMEOUT = 50000,
    parameter int          TO_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic [15:0]       o_instr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_SUM,
        S_ERR
    } state_t;

    localparam int              MAX_N   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_N);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state_reg;
    logic [7:0]      hi_reg;
    logic [7:0]      sum_reg;
    logic [ADDR_W:0] cnt_reg;
    logic [ADDR_W:0] len_reg;
    logic [TO_W-1:0] to_cnt_reg;

    logic [7:0]      sum_next;
    logic [ADDR_W:0] cnt_next;
    logic [ADDR_W:0] len_next;
    logic            len_bad;
    logic            in_frame;
    logic            timed_out;

    assign sum_next  = sum_reg + i_byte;
    assign cnt_next  = cnt_reg + CNT_ONE;
    // A length byte of zero stands for a full 2^ADDR_W-word program.
    assign len_next  = (i_byte == 8'd0) ? LEN_MAX : (ADDR_W+1)'(i_byte);
    assign len_bad   = ({24'd0, i_byte} > 32'(MAX_N));
    assign in_frame  = (state_reg == S_LEN) || (state_reg == S_HI) ||
                       (state_reg == S_LO)  || (state_reg == S_SUM);
    assign timed_out = in_frame && !i_byte_valid && (to_cnt_reg == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg  <= S_IDLE;
            hi_reg     <= '0;
            sum_reg    <= '0;
            cnt_reg    <= '0;
            len_reg    <= '0;
            to_cnt_reg <= '0;
            o_instr    <= '0;
            o_addr     <= '0;
            o_we       <= 1'b0;
            o_hold     <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_we   <= 1'b0;
            o_done <= 1'b0;

            if (in_frame && !i_byte_valid && !timed_out)
                to_cnt_reg <= to_cnt_reg + TO_ONE;
            else
                to_cnt_reg <= '0;

            if (timed_out) begin
                state_reg <= S_ERR;
                o_err     <= 1'b1;
                o_busy    <= 1'b0;
            end else if (i_byte_valid) begin
                case (state_reg)
                    S_IDLE, S_ERR: begin
                        if (i_byte == SYNC) begin
                            state_reg <= S_LEN;
                            o_hold    <= 1'b1;
                            o_busy    <= 1'b1;
                            o_err     <= 1'b0;
                        end
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            state_reg <= S_ERR;
                            o_err     <= 1'b1;
                            o_busy    <= 1'b0;
                        end else begin
                            len_reg   <= len_next;
                            cnt_reg   <= '0;
                            sum_reg   <= i_byte;
                            state_reg <= S_HI;
                        end
                    end
                    S_HI: begin
                        hi_reg    <= i_byte;
                        sum_reg   <= sum_next;
                        state_reg <= S_LO;
                    end
                    S_LO: begin
                        sum_reg   <= sum_next;
                        o_instr   <= {hi_reg, i_byte};
                        o_addr    <= cnt_reg[ADDR_W-1:0];
                        o_we      <= 1'b1;
                        cnt_reg   <= cnt_next;
                        state_reg <= (cnt_next == len_reg) ? S_SUM : S_HI;
                    end
                    S_SUM: begin
                        sum_reg <= sum_next;
                        o_busy  <= 1'b0;
                        if (sum_next == 8'd0) begin
                            o_done    <= 1'b1;
                            o_hold    <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            o_err     <= 1'b1;
                            state_reg <= S_ERR;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: hand sequences, a table of frames and random frames
// compared against a frame-level model (expected writes, checksum verdict).
module tb_prog_loader;

    localparam int         ADDR_W  = 8;
    localparam int         TIMEOUT = 100;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              we, hold, busy, done, err;

    prog_loader #(
        .ADDR_W(ADDR_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT), .TO_W(16)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_byte(in_byte), .i_byte_valid(in_valid),
        .o_instr(instr), .o_addr(addr), .o_we(we), .o_hold(hold),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int we_double = 0;
    logic we_prev = 1'b0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [15:0]       obs_data[$];
    logic [15:0]       tx_words[$];

    typedef struct {
        int          n;
        logic [15:0] w0;
        int          delta;
        bit          garbage;
        bit          exp_done;
        bit          exp_err;
        bit          exp_hold;
    } vec_t;

    vec_t vecs[6];

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (we) begin
            obs_addr.push_back(addr);
            obs_data.push_back(instr);
            if (we_prev) we_double++;
        end
        we_prev = we;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int max_gap);
        int g;
        g = $urandom_range(0, max_gap);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        we_double = 0;
    endtask

    // Sends tx_words as a frame; checksum is corrected, then offset by delta.
    task automatic run_frame(input int delta, input bit garbage, input int max_gap,
                             input bit exp_done, input bit exp_err, input bit exp_hold,
                             input string tag);
        int n, done0, m;
        logic [7:0] s, cks;
        n = tx_words.size();
        clear_obs();
        done0 = done_cnt;
        if (garbage) begin
            send_byte(8'h00);
            send_byte(8'hFF);
            @(negedge clk);
            check({tag, "_garbage_busy"}, busy, 0);
        end
        send_byte(SYNC);
        gap(max_gap);
        s = 8'(n);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            gap(max_gap);
            send_byte(tx_words[i][15:8]);
            s = s + tx_words[i][15:8];
            gap(max_gap);
            send_byte(tx_words[i][7:0]);
            s = s + tx_words[i][7:0];
        end
        gap(max_gap);
        cks = 8'd0 - s;
        cks = cks + 8'(delta);
        send_byte(cks);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_nwrites"}, obs_addr.size(), n);
        m = (obs_addr.size() < n) ? obs_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            check({tag, "_wr_addr"}, obs_addr[i], 32'(i[ADDR_W-1:0]));
            check({tag, "_wr_data"}, obs_data[i], tx_words[i]);
        end
        check({tag, "_done_pulses"}, done_cnt - done0, exp_done ? 1 : 0);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_hold"}, hold, exp_hold);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we_width"}, we_double, 0);
    endtask

    initial begin
        vecs[0] = '{1, 16'h1234, 0,  0, 1, 0, 0};
        vecs[1] = '{3, 16'hA5A5, 0,  1, 1, 0, 0};
        vecs[2] = '{2, 16'hFFFF, 7,  0, 0, 1, 1};
        vecs[3] = '{4, 16'h0000, 0,  0, 1, 0, 0};
        vecs[4] = '{1, 16'h00A5, 128, 1, 0, 1, 1};
        vecs[5] = '{2, 16'h8000, 0,  1, 1, 0, 0};

        rst_n    = 1'b0;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", hold, 1);
        check("rst_busy", busy, 0);
        check("rst_we", we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_instr", instr, 0);
        check("rst_addr", addr, 0);
        rst_n = 1'b1;

        // Cycle-exact reference frame.
        send_byte(8'hA5);
        @(negedge clk);
        check("b_hold_rise", hold, 1);
        check("b_busy_rise", busy, 1);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        check("b_we0", we, 1);
        check("b_instr0", instr, 16'h1234);
        check("b_addr0", addr, 0);
        send_byte(8'hAB);
        @(negedge clk);
        check("b_we_low", we, 0);
        send_byte(8'hCD);
        @(negedge clk);
        check("b_we1", we, 1);
        check("b_instr1", instr, 16'hABCD);
        check("b_addr1", addr, 1);
        send_byte(8'h40);
        @(negedge clk);
        check("b_done", done, 1);
        check("b_hold_fall", hold, 0);
        check("b_busy_fall", busy, 0);
        check("b_err", err, 0);
        @(negedge clk);
        check("b_done_width", done, 0);

        tx_words = '{16'h1234, 16'hABCD};
        run_frame(1, 0, 0, 0, 1, 1, "badcks");
        run_frame(0, 0, 0, 1, 0, 0, "recover");
        run_frame(0, 1, 0, 1, 0, 0, "garbage");

        foreach (vecs[v]) begin
            tx_words.delete();
            for (int i = 0; i < vecs[v].n; i++) tx_words.push_back(vecs[v].w0 + 16'(i));
            run_frame(vecs[v].delta, vecs[v].garbage, 2,
                      vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_hold, "table");
        end

        // Timeout inside a frame.
        clear_obs();
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        check("to_err_early", err, 0);
        check("to_busy_early", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_hold", hold, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("to_no_we", obs_addr.size(), 0);

        tx_words.delete();
        for (int i = 0; i < 256; i++) tx_words.push_back(16'(i));
        run_frame(0, 0, 0, 1, 0, 0, "full256");

        // Reset while the LO byte is being offered.
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h12);
        in_byte  = 8'h34;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_hold", hold, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_instr", instr, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_err", err, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid_rst_we", we, 0);
        #2;
        rst_n = 1'b1;
        tx_words = '{16'hBEEF};
        run_frame(0, 0, 0, 1, 0, 0, "post_rst");

        for (int r = 0; r < 30; r++) begin
            int n, delta;
            n = $urandom_range(1, 8);
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom));
            delta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
            run_frame(delta, 1'($urandom_range(0, 1)), 3,
                      delta == 0, delta != 0, delta != 0, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader sitting directly upstream of the CPU's instruction-memory write port. Receives a framed program (sync, length, 16-bit instructions high byte first, checksum) from a byte source such as a UART receiver. Drives instruction words, write strobes and a CPU hold line. Keeps the CPU in reset until a complete, checksum-valid program has been written.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; max program length 2^ADDR_W words
- SYNC, 8'hA5, frame start byte
- TIMEOUT, 50000, max clock cycles between bytes inside a frame (TO_W = 16-bit counter)

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_byte  in  8  received byte; valid only when i_byte_valid=1
- i_byte_valid  in  1  one-cycle strobe per byte; may be asserted on consecutive cycles
- o_instr  out  16  instruction word to instruction memory din
- o_addr  out  ADDR_W  word index of o_instr, valid with o_we
- o_we  out  1  one-cycle write strobe to instruction memory
- o_hold  out  1  high = CPU must be held in reset
- o_busy  out  1  high while a frame is in progress
- o_done  out  1  one-cycle pulse on a successful load
- o_err  out  1  sticky error flag, cleared by the next SYNC byte

## Operation
- States: IDLE, LEN, HI, LO, SUM, ERR.
- IDLE: non-SYNC bytes are ignored. A SYNC byte moves the FSM to LEN and sets o_hold=1, o_busy=1, o_err=0.
- LEN: byte sets N. Value 0 encodes 2^ADDR_W; for ADDR_W<8, values above 2^ADDR_W go to ERR. Word counter clears to 0 and the running sum loads with the byte. Next state HI.
- HI: byte latched into hi register; sum += byte. Next state LO.
- LO: byte latched; sum += byte. On the next edge: o_instr={hi,byte}, o_addr=counter, o_we=1, counter++. Next state SUM if the word just written was word N-1, else HI.
- SUM: byte added to sum.
  - (sum+byte) mod 256 == 0: o_done pulses, o_hold=0, o_busy=0, go IDLE.
  - Otherwise: o_err=1, go ERR; o_hold stays 1.
- ERR: o_busy=0, o_hold=1. Non-SYNC bytes are ignored. A SYNC byte behaves exactly as in IDLE.
- Timeout: in LEN/HI/LO/SUM a cycle counter clears on each accepted byte and increments otherwise. Reaching TIMEOUT goes to ERR with o_err=1. The counter holds at 0 in IDLE/ERR.
- A SYNC value received mid-frame is treated as data, not a restart.
- Words already written before an error stay in memory. The CPU stays held until a valid frame completes.
- Sum arithmetic is 8-bit modulo; counter is ADDR_W+1 bits so that N=2^ADDR_W terminates correctly.

## Timing
- Reset (async): state IDLE, o_instr=0, o_addr=0, o_we=0, o_hold=1, o_busy=0, o_done=0, o_err=0, sum=0, counters=0.
- All outputs are registered; none depend combinationally on inputs.
- One byte is accepted per cycle with no stall; there is no backpressure.
- o_we rises the cycle after the LO byte strobe and lasts exactly 1 cycle. o_instr/o_addr are stable from that edge until the next write.
- o_done and the o_hold fall happen on the edge after the checksum strobe; o_done lasts 1 cycle.
- o_hold rises on the edge after the SYNC strobe.
- o_busy rises with o_hold. It falls on the edge where the FSM enters IDLE or ERR.
- Timeout error asserts on the edge where the idle count reaches TIMEOUT.
- Reset asserted mid-frame aborts immediately: partial program is discarded as invalid and o_hold=1.
- Minimum frame of N words takes 2N+3 byte cycles; last o_we occurs 1 cycle before the checksum strobe at the earliest.

## Test plan
- Reset then bytes A5,02,12,34,AB,CD,40 on consecutive cycles -> o_we at word 0 with 0x1234, then word 1 with 0xABCD; o_done pulse; o_hold 1→0; o_err=0.
- Same frame with checksum 41 -> both words written; o_err=1, o_hold stays 1, no o_done. A following valid frame clears o_err and releases o_hold.
- Bytes 00,FF,A5 before a valid frame -> 00 and FF ignored (no state change); load succeeds.
- TIMEOUT=100; send A5,03,11, then idle 100 cycles -> o_err=1 on cycle 100, o_busy=0, o_hold=1, no further o_we.
- Length byte 00 with 256 words 0x0000..0x00FF plus correct checksum -> 256 o_we pulses, o_addr 0..255 in order; o_done once.
- Assert i_rst low mid-LO, release, send a valid 1-word frame -> all outputs at reset values during reset; single write at o_addr 0; o_done.
